// File: rtl/bus_pkg.sv
// Shared definitions for the core memory bus: FSM state codes, write strobes
// and an address helper.
package bus_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RD_GAP = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_WR_GAP = 3'd4;

  localparam logic [3:0]  WSTRB_READ = 4'h0;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [29:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/dma_copy_if.sv
// Core memory bus: a single valid/ready channel carrying both reads and writes.
interface dma_copy_if;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/bus_timeout.sv
// Per-transaction wait counter; expired is high on the LIMIT-th enabled cycle
// since the last clear.
module bus_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/dma_copy.sv
// Word-by-word memory copy engine: read one word, write it, repeat; every bus
// phase is bounded by a timeout that aborts the whole copy.
module dma_copy
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic               error,
  dma_copy_if.master         mem
);

  logic [2:0]         state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               expired_s;
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^{src_addr[1:0], dst_addr[1:0]};

  bus_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (!valid_q),
    .enable  (valid_q),
    .expired (expired_s)
  );

  // Copy sequencer; a completed handshake always wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = word_align(src_addr[31:2]);
          dst_d   = word_align(dst_addr[31:2]);
          cnt_d   = word_count;
          error_d = 1'b0;
          if (word_count == {COUNT_W{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RD;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            addr_d  = word_align(src_addr[31:2]);
            wstrb_d = WSTRB_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem.mem_ready) begin
          data_d  = mem.mem_rdata;
          valid_d = 1'b0;
          state_d = ST_RD_GAP;
        end else if (expired_s) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_RD_GAP: begin
        state_d = ST_WR;
        valid_d = 1'b1;
        addr_d  = dst_q;
        wdata_d = data_q;
        wstrb_d = WSTRB_WORD;
      end
      ST_WR: begin
        if (mem.mem_ready) begin
          src_d   = src_q + WORD_BYTES;
          dst_d   = dst_q + WORD_BYTES;
          cnt_d   = cnt_q - COUNT_W'(1'b1);
          valid_d = 1'b0;
          wstrb_d = WSTRB_READ;
          state_d = ST_WR_GAP;
        end else if (expired_s) begin
          valid_d = 1'b0;
          wstrb_d = WSTRB_READ;
          busy_d  = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_WR_GAP: begin
        if (cnt_q != {COUNT_W{1'b0}}) begin
          state_d = ST_RD;
          valid_d = 1'b1;
          addr_d  = src_q;
          wstrb_d = WSTRB_READ;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        wstrb_d = WSTRB_READ;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      src_q   <= 32'h0000_0000;
      dst_q   <= 32'h0000_0000;
      cnt_q   <= {COUNT_W{1'b0}};
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= WSTRB_READ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign mem.mem_valid = valid_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait for mem_ready per transaction before abort.
REQ-002 The block SHALL have parameter COUNT_W, default 16, giving the width of word_count.
REQ-003 clk  in  1  single system clock, all logic rising-edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  in  32  source byte address; bits [1:0] ignored.
REQ-007 dst_addr  in  32  destination byte address; bits [1:0] ignored.
REQ-008 word_count  in  COUNT_W  number of 32-bit words to copy.
REQ-009 busy  out  1  high from the cycle after start is accepted until the copy ends.
REQ-010 done  out  1  one-cycle pulse at the end of every accepted copy, including error and zero-length copies.
REQ-011 error  out  1  sticky timeout flag, cleared by the next accepted start.
REQ-012 mem_valid  out  1  bus request, initiator side of the core memory bus.
REQ-013 mem_ready  in  1  responder acknowledge.
REQ-014 mem_addr  out  32  word-aligned bus address.
REQ-015 mem_wdata  out  32  write data.
REQ-016 mem_wstrb  out  4  4'h0 for a read, 4'hF for a write.
REQ-017 mem_rdata  in  32  read data, valid when mem_ready is high.

Function
REQ-018 The FSM SHALL have states IDLE, RD, RD_GAP, WR, WR_GAP; all outputs SHALL be registered.
REQ-019 In IDLE with start=1, the block SHALL latch src/dst with [1:0] forced to 0 and latch word_count; if the count is 0 it SHALL pulse done next cycle with no bus activity, otherwise it SHALL enter RD with mem_valid=1 next cycle.
REQ-020 In RD: mem_valid=1, mem_addr=src, mem_wstrb=0; all three SHALL be held stable until mem_ready=1 is sampled.
REQ-021 On mem_ready in RD, the block SHALL capture mem_rdata into the data register and enter RD_GAP with mem_valid=0 for exactly one cycle, then enter WR.
REQ-022 In WR: mem_valid=1, mem_addr=dst, mem_wdata=captured data, mem_wstrb=4'hF, all held stable until mem_ready=1.
REQ-023 On mem_ready in WR, src and dst SHALL each increment by 4 (wrapping modulo 2^32), the remaining count SHALL decrement, and the FSM SHALL enter WR_GAP (mem_valid=0 for one cycle).
REQ-024 From WR_GAP, the FSM SHALL go to RD if the remaining count is nonzero; otherwise it SHALL go to IDLE, drop busy and pulse done in that same cycle.
REQ-025 A word SHALL therefore cost 4 + (read wait) + (write wait) cycles, where a wait is the number of cycles mem_valid is high before mem_ready.
REQ-026 mem_ready SHALL be ignored when mem_valid=0 and in IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Timeout: a per-transaction counter SHALL clear on every mem_valid rise; if it reaches TIMEOUT_CYCLES without mem_ready, the FSM SHALL drop mem_valid, go to IDLE, set error, and pulse done.
REQ-029 If mem_ready arrives in the same cycle the timeout limit is reached, the transaction SHALL complete normally and no error SHALL be raised.
REQ-030 mem_wdata SHALL hold its last value outside WR; verification SHALL check it only while mem_wstrb is nonzero.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE and clear busy, done, error, mem_valid, mem_addr, mem_wdata, mem_wstrb, the counters and the data register to 0.
REQ-032 A reset during a transfer SHALL abort it with no done pulse; after reset deasserts the block SHALL be idle and accept start.

Structure
REQ-033 The state encoding and the WSTRB_READ/WSTRB_WORD constants SHALL live in the shared bus_pkg package.
REQ-034 The timeout counter SHALL be one sub-module, bus_timeout (inputs: clear, enable; output: expired).

Verification
REQ-035 src=0x100, dst=0x200, count=3, RAM ready 1 cycle after valid -> 3 reads at 0x100/104/108 and 3 writes at 0x200/204/208 with matching data; done after 18 cycles; error=0.
REQ-036 count=0 -> done one cycle after start, mem_valid never high, busy never high.
REQ-037 Responder never asserts ready, TIMEOUT_CYCLES=8 -> mem_valid falls after 8 cycles, error=1, done pulse; the next start clears error.
REQ-038 src=0xFFFFFFFC, count=2 -> second read at 0x00000000 (wrap).
REQ-039 Second start pulsed mid-copy -> ignored; transaction count unchanged.
REQ-040 resetn asserted while in WR with mem_valid=1 -> mem_valid=0 immediately (async), no done; a subsequent start with count=1 completes normally.
